// File: rtl/sel_scan_pkg.sv
// Shared types and helpers for the select-scan sequencer.
// Select encoding is the 2-bit decoder index {s1,s0}.
package sel_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [1:0] SEL_FIRST_UP = 2'd0;
    localparam logic [1:0] SEL_LAST_UP  = 2'd3;

    // Expected decoder word for a given select: exactly bit 'sel' high.
    function automatic logic [3:0] onehot4(input logic [1:0] sel);
        onehot4 = 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/sel_dwell_timer.sv
// Loadable dwell counter: holds the captured dwell and flags when the
// running count has reached it, so each select lasts dwell_q+1 cycles.
module sel_dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_clr,
    input  logic               i_en,
    output logic               o_term
);

    logic [DWELL_W-1:0] r_dwell_q;
    logic [DWELL_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell_q <= '0;
            r_cnt     <= '0;
        end else if (i_load) begin
            r_dwell_q <= i_dwell;
            r_cnt     <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_term = (r_cnt == r_dwell_q);

endmodule

// File: rtl/sel_scan_sequencer.sv
// Select sequencer for the 2-to-4 NOR decoder: sweeps {s1,s0} up or down
// with a programmable dwell. Define SEL_SCAN_DECODE_CHECK_EN to add the
// returned-decoder-word checker.
module sel_scan_sequencer
    import sel_scan_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    output logic               s0,
    output logic               s1,
    output logic               sel_valid,
    output logic               busy,
    output logic               sweep_done
`ifdef SEL_SCAN_DECODE_CHECK_EN
    ,
    input  logic [3:0]         d_in,
    input  logic               err_clr,
    output logic               chk_err,
    output logic [1:0]         chk_err_idx
`endif
);

    state_t     r_state;
    logic [1:0] r_sel;
    logic       r_mode;
    logic       r_dir;
    logic       r_valid;
    logic       r_busy;
    logic       r_done;

    logic       w_accept;
    logic       w_term;
    logic       w_tmr_clr;
    logic       w_tmr_en;
    logic [1:0] w_first;
    logic [1:0] w_last;

    assign w_accept  = (r_state == IDLE) && start && !stop;
    assign w_first   = r_dir ? SEL_LAST_UP : SEL_FIRST_UP;
    assign w_last    = r_dir ? SEL_FIRST_UP : SEL_LAST_UP;
    assign w_tmr_en  = (r_state == RUN);
    assign w_tmr_clr = (r_state == IDLE) || stop || w_term;

    sel_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept),
        .i_dwell (dwell),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .o_term  (w_term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sel   <= 2'd0;
            r_mode  <= 1'b0;
            r_dir   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_sel   <= 2'd0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    if (w_accept) begin
                        r_mode  <= mode;
                        r_dir   <= dir;
                        r_sel   <= dir ? SEL_LAST_UP : SEL_FIRST_UP;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state <= IDLE;
                        r_sel   <= 2'd0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_term) begin
                        // Termination is decided by the explicit last-select
                        // compare, never by 2-bit wraparound.
                        if (r_sel != w_last) begin
                            r_sel <= r_dir ? (r_sel - 2'd1) : (r_sel + 2'd1);
                        end else if (r_mode) begin
                            r_sel  <= w_first;
                            r_done <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            r_sel   <= 2'd0;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s1         = r_sel[1];
    assign s0         = r_sel[0];
    assign sel_valid  = r_valid;
    assign busy       = r_busy;
    assign sweep_done = r_done;

`ifdef SEL_SCAN_DECODE_CHECK_EN
    logic       r_chk_err;
    logic [1:0] r_chk_idx;
    logic       w_mismatch;

    // d_in is a combinational function of the registered selects, so it is
    // compared against the select presented in the same cycle.
    assign w_mismatch = r_valid && (d_in != onehot4(r_sel));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_err <= 1'b0;
            r_chk_idx <= 2'd0;
        end else if (w_mismatch) begin
            r_chk_err <= 1'b1;
            if (!r_chk_err) r_chk_idx <= r_sel;
        end else if (err_clr) begin
            r_chk_err <= 1'b0;
            r_chk_idx <= 2'd0;
        end
    end

    assign chk_err     = r_chk_err;
    assign chk_err_idx = r_chk_idx;
`endif

endmodule
